// File: rtl/sram_like_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_resp_pkg
// Description : Shared definitions for the SRAM-like responder: transfer size
//               encodings, LFSR polynomial and the response-queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_like_resp_pkg;

    // Transfer size encodings (carried on the bus, informational only here)
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Galois tap mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] c_lfsr_poly = 32'h8020_0003;

    // One outstanding response: kind, captured read word and remaining delay
    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [2:0]  delay;
    } resp_entry_t;

    // One step of the right-shifting Galois LFSR
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        lfsr_step = {1'b0, cur[31:1]} ^ (cur[0] ? c_lfsr_poly : 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_fifo
// Description : In-order response queue. The head entry's delay field counts
//               down once per cycle while nonzero; entries behind the head
//               keep their delay untouched until they reach the head.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_fifo
    import sram_like_resp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  resp_entry_t       i_push_entry,
    input  logic              i_pop,
    output logic              o_head_valid,
    output resp_entry_t       o_head_entry,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full
);

    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_entry_t      r_mem [DEPTH];
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_pw-1:0]  r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_do_push;
    logic w_do_pop;
    logic w_head_tick;

    // Pointer advance with wrap for depths that are not a power of two
    function automatic logic [c_pw-1:0] ptr_next(input logic [c_pw-1:0] p);
        ptr_next = (p == c_pw'(DEPTH - 1)) ? '0 : p + c_pw'(1);
    endfunction

    assign w_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !w_empty;
    // A head that is still waiting ages by one; it is never popped while nonzero
    assign w_head_tick = !w_empty && !w_do_pop && (r_mem[r_rd_ptr].delay != 3'd0);

    assign o_head_valid = !w_empty;
    assign o_head_entry = r_mem[r_rd_ptr];
    assign o_count      = r_count;

    // Entry storage: write at tail, age the head (never the same slot when both)
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
        if (w_head_tick) begin
            r_mem[r_rd_ptr].delay <= r_mem[r_rd_ptr].delay - 3'd1;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count as is
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_resp
// Description : SRAM-like slave responder with internal word memory,
//               addr_ok/data_ok handshake, bounded outstanding requests and
//               optional LFSR-driven acceptance gaps and response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_resp
    import sram_like_resp_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter int          MAX_OUTST = 2,
    parameter int          RAND_EN   = 1,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int c_cnt_w  = $clog2(MAX_OUTST + 1);
    localparam int c_words  = 2 ** MEM_AW;

    logic [31:0]        r_lfsr;
    logic [31:0]        r_mem [c_words];

    logic               w_gate;
    logic [2:0]         w_delay;
    logic [MEM_AW-1:0]  w_idx;
    logic [31:0]        w_rd_word;
    logic               w_accept;
    resp_entry_t        w_push_entry;
    logic               w_head_valid;
    resp_entry_t        w_head_entry;
    logic [c_cnt_w-1:0] w_count;
    logic               w_full;
    logic               w_unused;

    // Timing randomisation source: LFSR bits, or fixed minimum timing
    generate
        if (RAND_EN != 0) begin : g_rand
            assign w_gate  = r_lfsr[0];
            assign w_delay = r_lfsr[3:1];
        end else begin : g_fixed
            assign w_gate  = 1'b1;
            assign w_delay = 3'd0;
        end
    endgenerate

    // Word index ignores the byte offset and anything above the memory size
    assign w_idx     = addr[MEM_AW+1:2];
    assign w_rd_word = r_mem[w_idx];

    // Acceptance looks only at current occupancy, never at a same-cycle retire
    assign addr_ok  = req && !reset && !w_full && w_gate;
    assign w_accept = addr_ok;

    // Writes carry a zero data word so the response path needs no mux on wr
    assign w_push_entry.wr    = wr;
    assign w_push_entry.data  = wr ? 32'h0 : w_rd_word;
    assign w_push_entry.delay = w_delay;

    // The head retires as soon as its delay has run out; no back-pressure
    assign data_ok = w_head_valid && !reset && (w_head_entry.delay == 3'd0);
    assign rdata   = data_ok ? w_head_entry.data : 32'h0;

    // Size, byte offset, upper address bits and the stored kind are not needed
    assign w_unused = ^{size, addr[31:MEM_AW+2], addr[1:0], w_head_entry.wr};

    // Free-running LFSR, reloaded with the seed on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    // Byte-lane memory write at the accept edge; contents survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_accept && wr && wstrb[b]) begin
                r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    resp_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (c_cnt_w)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_accept),
        .i_push_entry (w_push_entry),
        .i_pop        (data_ok),
        .o_head_valid (w_head_valid),
        .o_head_entry (w_head_entry),
        .o_count      (w_count),
        .o_full       (w_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_resp
// Description : Bench for sram_like_resp. dut0 runs fixed timing with
//               directed vectors; dut1 runs LFSR timing against a reference
//               model of the queue, LFSR and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_resp;

    localparam logic [31:0] c_seed  = 32'h0000_0001;
    localparam logic [31:0] c_poly  = 32'h8020_0003;
    localparam logic [31:0] c_base1 = 32'h0000_0200;

    logic clk;
    logic reset;

    logic        r0_req, r0_wr;
    logic [1:0]  r0_size;
    logic [3:0]  r0_wstrb;
    logic [31:0] r0_addr, r0_wdata;
    logic        addr_ok0, data_ok0;
    logic [31:0] rdata0;

    logic        r1_req, r1_wr;
    logic [1:0]  r1_size;
    logic [3:0]  r1_wstrb;
    logic [31:0] r1_addr, r1_wdata;
    logic        addr_ok1, data_ok1;
    logic [31:0] rdata1;

    int n_tests = 0;
    int n_fail  = 0;

    sram_like_resp #(
        .MEM_AW(10), .MAX_OUTST(2), .RAND_EN(0), .LFSR_SEED(c_seed)
    ) dut0 (
        .clk(clk), .reset(reset), .req(r0_req), .wr(r0_wr), .size(r0_size),
        .wstrb(r0_wstrb), .addr(r0_addr), .wdata(r0_wdata),
        .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0)
    );

    sram_like_resp #(
        .MEM_AW(10), .MAX_OUTST(2), .RAND_EN(1), .LFSR_SEED(c_seed)
    ) dut1 (
        .clk(clk), .reset(reset), .req(r1_req), .wr(r1_wr), .size(r1_size),
        .wstrb(r1_wstrb), .addr(r1_addr), .wdata(r1_wdata),
        .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR for dut1
    logic [31:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= c_seed;
        else       m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? c_poly : 32'h0);
    end

    // Reference queue and memory for dut1
    typedef struct {
        logic [31:0] data;
        int          cnt;
    } ent_t;
    ent_t        q[$];
    logic [31:0] m_mem [1024];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One dut0 cycle: drive, compare outputs at the falling edge, step
    task automatic cyc0(input string tag, input logic rq, input logic w,
                        input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                        input logic e_aok, input logic e_dok, input logic [31:0] e_rd);
        r0_req = rq; r0_wr = w; r0_wstrb = s; r0_addr = a; r0_wdata = d;
        @(negedge clk);
        check({tag, ".aok"}, 32'(addr_ok0), 32'(e_aok));
        check({tag, ".dok"}, 32'(data_ok0), 32'(e_dok));
        if (e_dok) check({tag, ".rdata"}, rdata0, e_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        int          init_idx;
        logic        e_aok, e_dok;
        logic [9:0]  idx;

        reset = 1'b1;
        r0_req = 0; r0_wr = 0; r0_size = 2'd2; r0_wstrb = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_wr = 0; r1_size = 2'd2; r1_wstrb = 0; r1_addr = 0; r1_wdata = 0;

        // Reset state, with a request pending on the bus
        repeat (2) @(posedge clk);
        #1 r0_req = 1'b1;
        @(negedge clk);
        check("rst.aok",   32'(addr_ok0), 32'd0);
        check("rst.dok",   32'(data_ok0), 32'd0);
        check("rst.rdata", rdata0, 32'h0);
        check("rst.count", 32'(dut0.u_fifo.r_count), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        r0_req = 1'b0;

        // Full write, read back, byte-lane merge, zero-strobe write, wrap
        cyc0("wr10",   1, 1, 4'hF,    32'h10,   32'hDEADBEEF, 1, 0, 32'h0);
        cyc0("rd10",   1, 0, 4'h0,    32'h10,   32'h0,        1, 1, 32'h0);
        cyc0("wrlane", 1, 1, 4'b0010, 32'h11,   32'h0000AA00, 1, 1, 32'hDEADBEEF);
        cyc0("rdlane", 1, 0, 4'h0,    32'h10,   32'h0,        1, 1, 32'h0);
        // Lane 1 (bits 15:8) replaced by AA, other lanes untouched
        cyc0("wrzero", 1, 1, 4'h0,    32'h10,   32'hFFFFFFFF, 1, 1, 32'hDEADAAEF);
        cyc0("rdzero", 1, 0, 4'h0,    32'h10,   32'h0,        1, 1, 32'h0);
        cyc0("wr0",    1, 1, 4'hF,    32'h0,    32'h12345678, 1, 1, 32'hDEADAAEF);
        cyc0("rdwrap", 1, 0, 4'h0,    32'h1000, 32'h0,        1, 1, 32'h0);
        cyc0("idle0",  0, 0, 4'h0,    32'h0,    32'h0,        0, 1, 32'h12345678);
        cyc0("idle1",  0, 0, 4'h0,    32'h0,    32'h0,        0, 0, 32'h0);

        // Back-to-back writes then reads with req held high: in-order responses
        cyc0("pw0", 1, 1, 4'hF, 32'h20, 32'hA0A0_0000, 1, 0, 32'h0);
        cyc0("pw1", 1, 1, 4'hF, 32'h24, 32'hA1A1_1111, 1, 1, 32'h0);
        cyc0("pw2", 1, 1, 4'hF, 32'h28, 32'hA2A2_2222, 1, 1, 32'h0);
        cyc0("pw3", 1, 1, 4'hF, 32'h2C, 32'hA3A3_3333, 1, 1, 32'h0);
        cyc0("pr0", 1, 0, 4'h0, 32'h20, 32'h0,         1, 1, 32'h0);
        cyc0("pr1", 1, 0, 4'h0, 32'h24, 32'h0,         1, 1, 32'hA0A0_0000);
        check("stream.count", 32'(dut0.u_fifo.r_count), 32'd1);
        cyc0("pr2", 1, 0, 4'h0, 32'h28, 32'h0,         1, 1, 32'hA1A1_1111);
        cyc0("pr3", 1, 0, 4'h0, 32'h2C, 32'h0,         1, 1, 32'hA2A2_2222);
        cyc0("pi0", 0, 0, 4'h0, 32'h0,  32'h0,         0, 1, 32'hA3A3_3333);
        cyc0("pi1", 0, 0, 4'h0, 32'h0,  32'h0,         0, 0, 32'h0);

        // Reset while a read is outstanding: response must be discarded
        cyc0("rdrst", 1, 0, 4'h0, 32'h20, 32'h0, 1, 0, 32'h0);
        reset = 1'b1; r0_req = 1'b1; r0_addr = 32'h24;
        @(negedge clk);
        check("midrst.aok", 32'(addr_ok0), 32'd0);
        check("midrst.dok", 32'(data_ok0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; r0_req = 1'b0;
        @(negedge clk);
        check("postrst.dok",   32'(data_ok0), 32'd0);
        check("postrst.count", 32'(dut0.u_fifo.r_count), 32'd0);
        @(posedge clk); #1;
        cyc0("rdkeep", 1, 0, 4'h0, 32'h28, 32'h0, 1, 0, 32'h0);
        cyc0("rdkeepd", 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hA2A2_2222);

        // dut1: preload 16 words, then random traffic, then drain
        init_idx = 0;
        for (int cyc = 0; cyc < 1120; cyc++) begin
            if (init_idx < 16) begin
                r1_req = 1; r1_wr = 1; r1_wstrb = 4'hF;
                r1_addr = c_base1 + 32'(init_idx * 4);
                r1_wdata = $urandom;
            end else if (cyc < 1080) begin
                r1_req   = ($urandom_range(0, 3) != 0);
                r1_wr    = 1'($urandom_range(0, 1));
                r1_wstrb = 4'($urandom_range(0, 15));
                r1_addr  = c_base1 + 32'($urandom_range(0, 15) * 4)
                         + 32'($urandom_range(0, 3)) + 32'($urandom_range(0, 1) * 32'h1000);
                r1_wdata = $urandom;
            end else begin
                r1_req = 0;
            end
            @(negedge clk);
            e_aok = r1_req && (q.size() < 2) && m_lfsr[0];
            e_dok = (q.size() > 0) && (q[0].cnt == 0);
            check("rnd.aok",   32'(addr_ok1), 32'(e_aok));
            check("rnd.dok",   32'(data_ok1), 32'(e_dok));
            check("rnd.count", 32'(dut1.u_fifo.r_count), 32'(q.size()));
            if (e_dok) check("rnd.rdata", rdata1, q[0].data);
            // Advance the reference to the state after the coming edge
            if (q.size() > 0 && q[0].cnt > 0) q[0].cnt--;
            if (e_dok) void'(q.pop_front());
            if (e_aok) begin
                ent_t e;
                idx = r1_addr[11:2];
                e.data = r1_wr ? 32'h0 : m_mem[idx];
                e.cnt  = int'(m_lfsr[3:1]);
                if (r1_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (r1_wstrb[b]) m_mem[idx][8*b +: 8] = r1_wdata[8*b +: 8];
                end
                q.push_back(e);
                if (init_idx < 16) init_idx++;
            end
            @(posedge clk); #1;
        end
        check("rnd.drained", 32'(q.size()), 32'd0);
        check("rnd.preload", 32'(init_idx), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
